superh16_lq_replay_sched: RTL and testbench
===========================================

SUPERH16_LQ_REPLAY_SCHED -- requirements
Module: superh16_lq_replay_sched

Interface
REQ-001 SHALL have parameter RS_ENTRIES, default 16, replay-buffer depth.
REQ-002 SHALL have parameter NUM_PORTS, default NUM_LOAD_UNITS (2), number of park and replay ports.
REQ-003 SHALL have parameter MSHR_IDX_BITS, default 3, miss-handler index width.
REQ-004 SHALL have ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
park_valid[NUM_PORTS]  in  1  load missed D-cache; park it
park_lq_idx[NUM_PORTS]  in  LQ_IDX_BITS  load-queue entry of parked load
park_rob_idx[NUM_PORTS]  in  ROB_IDX_BITS  ROB index of parked load
park_mshr_idx[NUM_PORTS]  in  MSHR_IDX_BITS  MSHR awaited
park_accept[NUM_PORTS]  out  1  park taken this cycle
fill_valid  in  1  MSHR fill complete
fill_mshr_idx  in  MSHR_IDX_BITS  filled MSHR
replay_valid[NUM_PORTS]  out  1  replay request to load unit
replay_lq_idx[NUM_PORTS]  out  LQ_IDX_BITS  load to replay
replay_rob_idx[NUM_PORTS]  out  ROB_IDX_BITS  its ROB index
replay_ready[NUM_PORTS]  in  1  load unit accepts replay
rob_head_idx  in  ROB_IDX_BITS  oldest in-flight ROB index (age base)
flush  in  1  pipeline flush
flush_rob_idx  in  ROB_IDX_BITS  loads younger than this are killed
full  out  1  no free entry
occupancy  out  $clog2(RS_ENTRIES)+1  non-FREE entry count

Function
REQ-005 Each entry SHALL hold state FREE/WAIT/READY plus lq_idx, rob_idx, mshr_idx.
REQ-006 Age SHALL be (rob_idx - rob_head_idx) mod 2^ROB_IDX_BITS; smaller = older; used for every ordering and flush comparison, so wrap-around is correct.
REQ-007 park_accept[i] SHALL be combinational: park_valid[i] and free entries > count of park_valid[j], j<i; lowest-index free entries fill first.
REQ-008 Accepted park SHALL enter WAIT next cycle, or READY if fill_valid with matching mshr_idx in the same cycle.
REQ-009 fill_valid SHALL move every WAIT entry with matching mshr_idx to READY next cycle (one-cycle fill-to-replay latency).
REQ-010 replay_valid/lq_idx/rob_idx SHALL be combinational from registered state: port 0 oldest READY, port 1 second-oldest, etc.; ties impossible (unique rob_idx).
REQ-011 Selection SHALL not reorder on backpressure: a port with replay_ready=0 keeps its entry; no other port takes it that cycle.
REQ-012 Entry SHALL return to FREE the cycle after replay_valid and replay_ready both high on its port.
REQ-013 flush SHALL, next cycle, free every non-FREE entry with age > age(flush_rob_idx); while flush is high, replay_valid and park_accept SHALL be 0 and fill SHALL still update surviving entries.
REQ-014 full SHALL equal (occupancy == RS_ENTRIES); occupancy registered-state-based, consistent same cycle.
REQ-015 Simultaneous park, fill, replay and free in one cycle SHALL all take effect; a freed entry is reusable only from the next cycle.

Reset
REQ-016 rst_n low SHALL asynchronously set all entries FREE; outputs then: park_accept 0, replay_valid 0, replay_lq_idx 0, replay_rob_idx 0, full 0, occupancy 0.
REQ-017 Reset mid-operation SHALL drop all parked loads without any replay handshake.

Structure
REQ-018 rs_state_e enum and rs_entry_t struct SHALL live in superh16_pkg; MSHR_IDX_BITS default sourced there too.
REQ-019 A sub-module superh16_age_pick_n SHALL perform N-oldest selection over a valid mask and age vector.

Verification
REQ-020 Park lq 5/rob 10/mshr 2; fill mshr 2 next cycle -> replay_valid[0] one cycle after fill, lq_idx 5; ready=1 -> occupancy 0.
REQ-021 Park rob 250 and rob 3, rob_head 248, both filled -> port 0 gets 250, port 1 gets 3 (wrap).
REQ-022 Fill 16 entries -> full=1, park_accept 0; one replay handshake -> full=0 following cycle.
REQ-023 Entries rob 20,30,40 READY, flush_rob_idx 25, rob_head 0 -> only rob 20 remains; replay_valid 0 during flush.
REQ-024 Park and fill same mshr same cycle -> replay_valid asserted next cycle.
REQ-025 replay_ready[0]=0 for 3 cycles -> port 0 holds identical lq_idx; port 1 stays on second-oldest.

Source files
------------

// File: rtl/superh16_pkg.sv
// Shared types and widths for the SuperH16 load-queue replay scheduler.
//   rs_state_e : replay-buffer entry state
//   rs_entry_t : one replay-buffer entry payload
//   rob_age()  : ROB index distance from the current head (wrap-safe age)
package superh16_pkg;

  localparam int unsigned NUM_LOAD_UNITS        = 2;
  localparam int unsigned LQ_IDX_BITS           = 5;
  localparam int unsigned ROB_IDX_BITS          = 8;
  localparam int unsigned DEFAULT_MSHR_IDX_BITS = 3;

  typedef enum logic [1:0] {
    RS_FREE  = 2'd0,
    RS_WAIT  = 2'd1,
    RS_READY = 2'd2
  } rs_state_e;

  typedef struct packed {
    rs_state_e                        state;
    logic [LQ_IDX_BITS-1:0]           lq_idx;
    logic [ROB_IDX_BITS-1:0]          rob_idx;
    logic [DEFAULT_MSHR_IDX_BITS-1:0] mshr_idx;
  } rs_entry_t;

  // Modular distance from the ROB head; smaller means older.
  function automatic logic [ROB_IDX_BITS-1:0] rob_age(
    input logic [ROB_IDX_BITS-1:0] rob,
    input logic [ROB_IDX_BITS-1:0] head
  );
    return rob - head;
  endfunction

endpackage

// File: rtl/superh16_age_pick_n.sv
// N-oldest selector: ranks every valid entry by age and reports the
// entries of rank 0..N_PICK-1 (oldest first). Ages of valid entries are
// assumed unique.
//   valid       : entry valid mask
//   age         : per-entry age, smaller = older
//   pick_valid_c: pick slot p holds an entry
//   pick_idx_c  : entry index for pick slot p
module superh16_age_pick_n #(
  parameter int unsigned N_ENTRIES = 16,
  parameter int unsigned N_PICK    = 2,
  parameter int unsigned AGE_W     = 8,
  parameter int unsigned IDX_W     = $clog2(N_ENTRIES)
) (
  input  logic [N_ENTRIES-1:0] valid,
  input  logic [AGE_W-1:0]     age [N_ENTRIES],
  output logic                 pick_valid_c [N_PICK],
  output logic [IDX_W-1:0]     pick_idx_c [N_PICK]
);

  localparam int unsigned RANK_W = $clog2(N_ENTRIES) + 1;

  logic [RANK_W-1:0] rank [N_ENTRIES];

  // Rank = number of valid entries strictly older than this one.
  always_comb begin
    for (int e = 0; e < int'(N_ENTRIES); e++) begin
      rank[e] = '0;
      for (int j = 0; j < int'(N_ENTRIES); j++) begin
        if (valid[j] && (j != e) && (age[j] < age[e])) begin
          rank[e] = rank[e] + RANK_W'(1);
        end
      end
    end
  end

  // Slot p takes the unique valid entry whose rank is p.
  always_comb begin
    for (int p = 0; p < int'(N_PICK); p++) begin
      pick_valid_c[p] = 1'b0;
      pick_idx_c[p]   = '0;
      for (int e = 0; e < int'(N_ENTRIES); e++) begin
        if (valid[e] && (rank[e] == RANK_W'(p))) begin
          pick_valid_c[p] = 1'b1;
          pick_idx_c[p]   = IDX_W'(e);
        end
      end
    end
  end

endmodule

// File: rtl/superh16_lq_replay_sched.sv
// Replay scheduler for loads that missed the D-cache. Missed loads park
// in WAIT until their MSHR fills, become READY, and are replayed oldest
// first across the load-unit ports. Flush kills parked loads younger
// than flush_rob_idx.
//   park_*      : park requests from each load unit, park_accept reply
//   fill_*      : MSHR fill completion
//   replay_*    : replay requests to load units with ready handshake
//   rob_head_idx: age base for ordering and flush comparisons
//   flush*      : pipeline flush and its boundary ROB index
//   full/occupancy: count of non-FREE entries
module superh16_lq_replay_sched
  import superh16_pkg::*;
#(
  parameter int unsigned RS_ENTRIES    = 16,
  parameter int unsigned NUM_PORTS     = NUM_LOAD_UNITS,
  parameter int unsigned MSHR_IDX_BITS = DEFAULT_MSHR_IDX_BITS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          park_valid    [NUM_PORTS],
  input  logic [LQ_IDX_BITS-1:0]        park_lq_idx   [NUM_PORTS],
  input  logic [ROB_IDX_BITS-1:0]       park_rob_idx  [NUM_PORTS],
  input  logic [MSHR_IDX_BITS-1:0]      park_mshr_idx [NUM_PORTS],
  output logic                          park_accept   [NUM_PORTS],
  input  logic                          fill_valid,
  input  logic [MSHR_IDX_BITS-1:0]      fill_mshr_idx,
  output logic                          replay_valid   [NUM_PORTS],
  output logic [LQ_IDX_BITS-1:0]        replay_lq_idx  [NUM_PORTS],
  output logic [ROB_IDX_BITS-1:0]       replay_rob_idx [NUM_PORTS],
  input  logic                          replay_ready   [NUM_PORTS],
  input  logic [ROB_IDX_BITS-1:0]       rob_head_idx,
  input  logic                          flush,
  input  logic [ROB_IDX_BITS-1:0]       flush_rob_idx,
  output logic                          full,
  output logic [$clog2(RS_ENTRIES):0]   occupancy
);

  localparam int unsigned OCC_W = $clog2(RS_ENTRIES) + 1;
  localparam int unsigned IDX_W = $clog2(RS_ENTRIES);
  localparam int unsigned PM_W  = DEFAULT_MSHR_IDX_BITS;

  rs_entry_t rs_q [RS_ENTRIES];
  rs_entry_t rs_d [RS_ENTRIES];

  logic [RS_ENTRIES-1:0]   ready_mask;
  logic [RS_ENTRIES-1:0]   free_mask;
  logic [RS_ENTRIES-1:0]   hs_mask;
  logic [ROB_IDX_BITS-1:0] age [RS_ENTRIES];
  logic [ROB_IDX_BITS-1:0] flush_age;
  logic                    pick_valid [NUM_PORTS];
  logic [IDX_W-1:0]        pick_idx [NUM_PORTS];
  logic [OCC_W-1:0]        occ_cnt;
  logic [OCC_W-1:0]        free_cnt;
  logic [OCC_W-1:0]        pv_cnt;
  logic [OCC_W-1:0]        prior [NUM_PORTS];
  logic [OCC_W-1:0]        ord;

  // Per-entry status decode and age relative to the ROB head.
  always_comb begin
    occ_cnt  = '0;
    free_cnt = '0;
    for (int e = 0; e < int'(RS_ENTRIES); e++) begin
      ready_mask[e] = (rs_q[e].state == RS_READY);
      free_mask[e]  = (rs_q[e].state == RS_FREE);
      age[e]        = rob_age(rs_q[e].rob_idx, rob_head_idx);
      if (free_mask[e]) free_cnt = free_cnt + OCC_W'(1);
      else              occ_cnt  = occ_cnt + OCC_W'(1);
    end
    flush_age = rob_age(flush_rob_idx, rob_head_idx);
  end

  assign occupancy = occ_cnt;
  assign full      = (occ_cnt == OCC_W'(RS_ENTRIES));

  // Port i is granted when enough free entries remain after all lower
  // requesting ports; prior[i] is its rank among requesters.
  always_comb begin
    pv_cnt = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      prior[i]       = pv_cnt;
      park_accept[i] = park_valid[i] && !flush && (free_cnt > pv_cnt);
      if (park_valid[i]) pv_cnt = pv_cnt + OCC_W'(1);
    end
  end

  superh16_age_pick_n #(
    .N_ENTRIES (RS_ENTRIES),
    .N_PICK    (NUM_PORTS),
    .AGE_W     (ROB_IDX_BITS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .valid        (ready_mask),
    .age          (age),
    .pick_valid_c (pick_valid),
    .pick_idx_c   (pick_idx)
  );

  // Replay outputs come straight from registered state; zeroed when idle.
  always_comb begin
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      replay_valid[p]   = pick_valid[p] && !flush;
      replay_lq_idx[p]  = '0;
      replay_rob_idx[p] = '0;
      if (replay_valid[p]) begin
        replay_lq_idx[p]  = rs_q[pick_idx[p]].lq_idx;
        replay_rob_idx[p] = rs_q[pick_idx[p]].rob_idx;
      end
    end
  end

  // Entries whose replay handshake completes this cycle.
  always_comb begin
    hs_mask = '0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      if (replay_valid[p] && replay_ready[p]) begin
        hs_mask[pick_idx[p]] = 1'b1;
      end
    end
  end

  // Next-state: fill wakeup, replay/flush release, then park into entries
  // that are FREE in the current state (released entries wait a cycle).
  always_comb begin
    ord = '0;
    for (int e = 0; e < int'(RS_ENTRIES); e++) begin
      rs_d[e] = rs_q[e];
      if ((rs_q[e].state == RS_WAIT) && fill_valid &&
          (rs_q[e].mshr_idx == PM_W'(fill_mshr_idx))) begin
        rs_d[e].state = RS_READY;
      end
      if (hs_mask[e]) begin
        rs_d[e].state = RS_FREE;
      end
      if (flush && !free_mask[e] && (age[e] > flush_age)) begin
        rs_d[e].state = RS_FREE;
      end
      if (free_mask[e]) begin
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
          if (park_accept[i] && (prior[i] == ord)) begin
            rs_d[e].lq_idx   = park_lq_idx[i];
            rs_d[e].rob_idx  = park_rob_idx[i];
            rs_d[e].mshr_idx = PM_W'(park_mshr_idx[i]);
            rs_d[e].state    = (fill_valid && (park_mshr_idx[i] == fill_mshr_idx))
                               ? RS_READY : RS_WAIT;
          end
        end
        ord = ord + OCC_W'(1);
      end
    end
  end

  // Entry state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < int'(RS_ENTRIES); e++) begin
        rs_q[e] <= '0;
      end
    end else begin
      for (int e = 0; e < int'(RS_ENTRIES); e++) begin
        rs_q[e] <= rs_d[e];
      end
    end
  end

endmodule

// File: tb/tb_superh16_lq_replay_sched.sv
// Directed, table-driven bench for superh16_lq_replay_sched.
module tb_superh16_lq_replay_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       park_valid    [2];
  logic [4:0] park_lq_idx   [2];
  logic [7:0] park_rob_idx  [2];
  logic [2:0] park_mshr_idx [2];
  logic       park_accept   [2];
  logic       fill_valid;
  logic [2:0] fill_mshr_idx;
  logic       replay_valid   [2];
  logic [4:0] replay_lq_idx  [2];
  logic [7:0] replay_rob_idx [2];
  logic       replay_ready   [2];
  logic [7:0] rob_head_idx;
  logic       flush;
  logic [7:0] flush_rob_idx;
  logic       full;
  logic [4:0] occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  superh16_lq_replay_sched dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .park_valid     (park_valid),
    .park_lq_idx    (park_lq_idx),
    .park_rob_idx   (park_rob_idx),
    .park_mshr_idx  (park_mshr_idx),
    .park_accept    (park_accept),
    .fill_valid     (fill_valid),
    .fill_mshr_idx  (fill_mshr_idx),
    .replay_valid   (replay_valid),
    .replay_lq_idx  (replay_lq_idx),
    .replay_rob_idx (replay_rob_idx),
    .replay_ready   (replay_ready),
    .rob_head_idx   (rob_head_idx),
    .flush          (flush),
    .flush_rob_idx  (flush_rob_idx),
    .full           (full),
    .occupancy      (occupancy)
  );

  // One cycle: inputs, then expected outputs sampled 1 ns after driving.
  typedef struct {
    int pv0, lq0, rob0, m0;
    int pv1, lq1, rob1, m1;
    int fv, fm, rr0, rr1, head, fl, frob;
    int ea0, ea1;
    int ev0, elq0, erob0;
    int ev1, elq1, erob1;
    int efull, eocc;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      park_valid[i] = 1'b0; park_lq_idx[i] = '0; park_rob_idx[i] = '0;
      park_mshr_idx[i] = '0; replay_ready[i] = 1'b0;
    end
    fill_valid = 1'b0; fill_mshr_idx = '0; flush = 1'b0; flush_rob_idx = '0;
  endtask

  task automatic drive(input vec_t v);
    park_valid[0] = 1'(v.pv0); park_lq_idx[0] = 5'(v.lq0);
    park_rob_idx[0] = 8'(v.rob0); park_mshr_idx[0] = 3'(v.m0);
    park_valid[1] = 1'(v.pv1); park_lq_idx[1] = 5'(v.lq1);
    park_rob_idx[1] = 8'(v.rob1); park_mshr_idx[1] = 3'(v.m1);
    fill_valid = 1'(v.fv); fill_mshr_idx = 3'(v.fm);
    replay_ready[0] = 1'(v.rr0); replay_ready[1] = 1'(v.rr1);
    rob_head_idx = 8'(v.head); flush = 1'(v.fl); flush_rob_idx = 8'(v.frob);
  endtask

  task automatic check_row(input int r, input vec_t v);
    chk($sformatf("r%0d park_accept0", r), 32'(park_accept[0]), v.ea0);
    chk($sformatf("r%0d park_accept1", r), 32'(park_accept[1]), v.ea1);
    chk($sformatf("r%0d replay_valid0", r), 32'(replay_valid[0]), v.ev0);
    chk($sformatf("r%0d replay_lq0", r), 32'(replay_lq_idx[0]), v.elq0);
    chk($sformatf("r%0d replay_rob0", r), 32'(replay_rob_idx[0]), v.erob0);
    chk($sformatf("r%0d replay_valid1", r), 32'(replay_valid[1]), v.ev1);
    chk($sformatf("r%0d replay_lq1", r), 32'(replay_lq_idx[1]), v.elq1);
    chk($sformatf("r%0d replay_rob1", r), 32'(replay_rob_idx[1]), v.erob1);
    chk($sformatf("r%0d full", r), 32'(full), v.efull);
    chk($sformatf("r%0d occupancy", r), 32'(occupancy), v.eocc);
  endtask

  initial begin
    //          pv0 lq  rob m   pv1 lq rob m  fv fm rr0 rr1 head fl frob ea0 ea1 ev0 lq rob ev1 lq rob full occ
    // Basic park, fill, replay
    tbl[0]  = '{1, 5, 10, 2,  0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0,   1, 0,  0, 0, 0,   0, 0, 0,   0, 0};
    tbl[1]  = '{0, 0, 0, 0,   0, 0, 0, 0,  1, 2, 0, 0,   0, 0, 0,   0, 0,  0, 0, 0,   0, 0, 0,   0, 1};
    tbl[2]  = '{0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 1, 0,   0, 0, 0,   0, 0,  1, 5, 10,  0, 0, 0,   0, 1};
    tbl[3]  = '{0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0,   0, 0,  0, 0, 0,   0, 0, 0,   0, 0};
    // ROB wrap ordering, head 248
    tbl[4]  = '{1, 1, 250, 1, 1, 2, 3, 1,  0, 0, 0, 0, 248, 0, 0,   1, 1,  0, 0, 0,   0, 0, 0,   0, 0};
    tbl[5]  = '{0, 0, 0, 0,   0, 0, 0, 0,  1, 1, 0, 0, 248, 0, 0,   0, 0,  0, 0, 0,   0, 0, 0,   0, 2};
    tbl[6]  = '{0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0, 0, 248, 0, 0,   0, 0,  1, 1, 250, 1, 2, 3,   0, 2};
    tbl[7]  = '{0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 1, 1, 248, 0, 0,   0, 0,  1, 1, 250, 1, 2, 3,   0, 2};
    tbl[8]  = '{0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0, 0, 248, 0, 0,   0, 0,  0, 0, 0,   0, 0, 0,   0, 0};
    // Flush keeps only rob 20; park and replay blocked during flush
    tbl[9]  = '{1, 3, 20, 3,  1, 4, 30, 3, 0, 0, 0, 0,   0, 0, 0,   1, 1,  0, 0, 0,   0, 0, 0,   0, 0};
    tbl[10] = '{1, 6, 40, 3,  0, 0, 0, 0,  1, 3, 0, 0,   0, 0, 0,   1, 0,  0, 0, 0,   0, 0, 0,   0, 2};
    tbl[11] = '{1, 9, 90, 3,  0, 0, 0, 0,  0, 0, 1, 1,   0, 1, 25,  0, 0,  0, 0, 0,   0, 0, 0,   0, 3};
    tbl[12] = '{0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0,   0, 0,  1, 3, 20,  0, 0, 0,   0, 1};
    tbl[13] = '{0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 1, 0,   0, 0, 0,   0, 0,  1, 3, 20,  0, 0, 0,   0, 1};
    tbl[14] = '{0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0,   0, 0,  0, 0, 0,   0, 0, 0,   0, 0};
    // Park and fill of the same MSHR in one cycle
    tbl[15] = '{1, 7, 50, 5,  0, 0, 0, 0,  1, 5, 0, 0,   0, 0, 0,   1, 0,  0, 0, 0,   0, 0, 0,   0, 0};
    tbl[16] = '{0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 1, 0,   0, 0, 0,   0, 0,  1, 7, 50,  0, 0, 0,   0, 1};
    tbl[17] = '{0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0,   0, 0,  0, 0, 0,   0, 0, 0,   0, 0};
    // Port 0 backpressure for three cycles
    tbl[18] = '{1, 8, 60, 4,  1, 9, 61, 4, 0, 0, 0, 0,   0, 0, 0,   1, 1,  0, 0, 0,   0, 0, 0,   0, 0};
    tbl[19] = '{1, 10, 62, 4, 0, 0, 0, 0,  1, 4, 0, 0,   0, 0, 0,   1, 0,  0, 0, 0,   0, 0, 0,   0, 2};
    tbl[20] = '{0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0, 1,   0, 0, 0,   0, 0,  1, 8, 60,  1, 9, 61,  0, 3};
    tbl[21] = '{0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0,   0, 0,  1, 8, 60,  1, 10, 62, 0, 2};
    tbl[22] = '{0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0,   0, 0,  1, 8, 60,  1, 10, 62, 0, 2};
    tbl[23] = '{0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 1, 1,   0, 0, 0,   0, 0,  1, 8, 60,  1, 10, 62, 0, 2};
    tbl[24] = '{0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0,   0, 0,  0, 0, 0,   0, 0, 0,   0, 0};

    // Reset state
    idle();
    rob_head_idx = '0;
    rst_n = 1'b0;
    #3;
    chk("reset park_accept0", 32'(park_accept[0]), 0);
    chk("reset replay_valid0", 32'(replay_valid[0]), 0);
    chk("reset replay_lq0", 32'(replay_lq_idx[0]), 0);
    chk("reset replay_rob0", 32'(replay_rob_idx[0]), 0);
    chk("reset full", 32'(full), 0);
    chk("reset occupancy", 32'(occupancy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < NV; r++) begin
      @(negedge clk);
      drive(tbl[r]);
      #1;
      check_row(r, tbl[r]);
    end

    // Fill all 16 entries, two per cycle
    idle();
    rob_head_idx = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        park_valid[i]    = 1'b1;
        park_lq_idx[i]   = 5'(2 * k + i);
        park_rob_idx[i]  = 8'(100 + 2 * k + i);
        park_mshr_idx[i] = 3'd6;
      end
      #1;
      chk($sformatf("fill%0d accept0", k), 32'(park_accept[0]), 1);
      chk($sformatf("fill%0d accept1", k), 32'(park_accept[1]), 1);
      chk($sformatf("fill%0d occupancy", k), 32'(occupancy), 2 * k);
    end
    @(negedge clk);
    park_rob_idx[0] = 8'd200; park_rob_idx[1] = 8'd201;
    #1;
    chk("full flag", 32'(full), 1);
    chk("full occupancy", 32'(occupancy), 16);
    chk("full accept0", 32'(park_accept[0]), 0);
    chk("full accept1", 32'(park_accept[1]), 0);
    @(negedge clk);
    park_valid[1] = 1'b0;
    fill_valid = 1'b1; fill_mshr_idx = 3'd6;
    #1;
    chk("full fill accept0", 32'(park_accept[0]), 0);
    chk("full fill replay_valid0", 32'(replay_valid[0]), 0);
    @(negedge clk);
    idle();
    replay_ready[0] = 1'b1;
    #1;
    chk("full replay_valid0", 32'(replay_valid[0]), 1);
    chk("full replay_rob0", 32'(replay_rob_idx[0]), 100);
    chk("full replay_lq0", 32'(replay_lq_idx[0]), 0);
    chk("full before release", 32'(full), 1);
    @(negedge clk);
    replay_ready[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      park_valid[i]    = 1'b1;
      park_lq_idx[i]   = 5'(20 + i);
      park_rob_idx[i]  = 8'(210 + i);
      park_mshr_idx[i] = 3'd7;
    end
    #1;
    chk("release full", 32'(full), 0);
    chk("release occupancy", 32'(occupancy), 15);
    chk("release accept0", 32'(park_accept[0]), 1);
    chk("release accept1", 32'(park_accept[1]), 0);
    chk("release replay_rob0", 32'(replay_rob_idx[0]), 101);
    chk("release replay_rob1", 32'(replay_rob_idx[1]), 102);

    // Asynchronous reset while the buffer is full
    @(negedge clk);
    idle();
    #1;
    chk("pre-reset occupancy", 32'(occupancy), 16);
    rst_n = 1'b0;
    #1;
    chk("async reset occupancy", 32'(occupancy), 0);
    chk("async reset full", 32'(full), 0);
    chk("async reset replay_valid0", 32'(replay_valid[0]), 0);
    chk("async reset replay_rob0", 32'(replay_rob_idx[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post-reset occupancy", 32'(occupancy), 0);
    chk("post-reset replay_valid1", 32'(replay_valid[1]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
